// File: rtl/spi_master.sv
// Single-channel SPI master: shifts one TRAN_WIDTH-bit word out on MOSI (MSB first)
// while capturing TRAN_WIDTH bits from MISO, with parameterised clock polarity and phases.
module spi_master #(
    parameter int IDLE_VALUE_for_Clk       = 1,
    parameter int IDLE_VALUE_for_MOSI      = 0,
    parameter int DATA_VALID_at_FALLING    = 0,
    parameter int TRAN_WIDTH               = 8,
    parameter int Receive_VALID_at_FALLING = 0,
    parameter int CLK_DIV                  = 2
) (
    input  logic                  c_Clk_High,
    input  logic                  i_Rst_n,
    input  logic                  i_SPI_Send_Sync,
    input  logic [TRAN_WIDTH-1:0] i_SPI_Send_Data,
    output logic                  o_SPI_Send_Over_ack,
    output logic                  o_SPI_Receive_Sync,
    output logic [TRAN_WIDTH-1:0] o_SPI_Receive_Data,
    output logic                  o_SPI_Clk,
    output logic                  o_SPI_SS,
    output logic                  o_SPI_MOSI,
    input  logic                  i_SPI_MISO
);

    localparam logic CPOL      = (IDLE_VALUE_for_Clk != 0);
    localparam logic MOSI_IDLE = (IDLE_VALUE_for_MOSI != 0);
    localparam logic TX_FALL   = (DATA_VALID_at_FALLING != 0);
    localparam logic RX_FALL   = (Receive_VALID_at_FALLING != 0);
    // The first SCLK toggle is the slave's valid edge, so the MSB must already be on MOSI.
    localparam logic LEAD_MSB  = (CPOL == TX_FALL);

    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int EDGE_W = $clog2(2 * TRAN_WIDTH + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * TRAN_WIDTH - 1);
    localparam logic [EDGE_W-1:0] EDGE_ONE  = EDGE_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_END  = 2'd2;

    logic [1:0]            state;
    logic                  send_sync_q;
    logic [DIV_W-1:0]      div_cnt;
    logic [EDGE_W-1:0]     edge_cnt;
    logic [TRAN_WIDTH-1:0] tx_shift;
    logic [TRAN_WIDTH-1:0] rx_shift;

    logic start;
    logic tick;
    logic first_cycle;
    logic toggle;
    logic tog_fall;
    logic launch;
    logic sample;

    assign start       = (state == ST_IDLE) && i_SPI_Send_Sync && !send_sync_q;
    assign tick        = (div_cnt == DIV_LAST);
    assign first_cycle = (state == ST_XFER) && (div_cnt == '0);
    assign toggle      = (state == ST_XFER) && tick;
    assign tog_fall    = o_SPI_Clk;
    // The final toggle never launches: all TRAN_WIDTH bits are already out by then.
    assign launch      = toggle && (tog_fall != TX_FALL) && (edge_cnt != EDGE_LAST);
    assign sample      = toggle && (tog_fall == RX_FALL);

    always_ff @(posedge c_Clk_High or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state               <= ST_IDLE;
            send_sync_q         <= 1'b0;
            div_cnt             <= '0;
            edge_cnt            <= '0;
            tx_shift            <= '0;
            rx_shift            <= '0;
            o_SPI_Send_Over_ack <= 1'b0;
            o_SPI_Receive_Sync  <= 1'b0;
            o_SPI_Receive_Data  <= '0;
            o_SPI_Clk           <= CPOL;
            o_SPI_SS            <= 1'b1;
            o_SPI_MOSI          <= MOSI_IDLE;
        end else begin
            send_sync_q         <= i_SPI_Send_Sync;
            o_SPI_Send_Over_ack <= 1'b0;
            o_SPI_Receive_Sync  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_XFER;
                        tx_shift <= i_SPI_Send_Data;
                        rx_shift <= '0;
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                    end
                end

                ST_XFER: begin
                    if (first_cycle) begin
                        o_SPI_SS <= 1'b0;
                    end
                    if ((first_cycle && LEAD_MSB) || launch) begin
                        o_SPI_MOSI <= tx_shift[TRAN_WIDTH-1];
                        tx_shift   <= {tx_shift[TRAN_WIDTH-2:0], 1'b0};
                    end
                    if (sample) begin
                        rx_shift <= {rx_shift[TRAN_WIDTH-2:0], i_SPI_MISO};
                    end
                    if (tick) begin
                        div_cnt   <= DIV_ONE;
                        o_SPI_Clk <= ~o_SPI_Clk;
                        edge_cnt  <= edge_cnt + EDGE_ONE;
                        if (edge_cnt == EDGE_LAST) begin
                            state <= ST_END;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end

                ST_END: begin
                    if (tick) begin
                        state               <= ST_IDLE;
                        o_SPI_SS            <= 1'b1;
                        o_SPI_MOSI          <= MOSI_IDLE;
                        o_SPI_Receive_Data  <= rx_shift;
                        o_SPI_Send_Over_ack <= 1'b1;
                        o_SPI_Receive_Sync  <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed self-checking bench for spi_master: three instances cover 8-bit and 16-bit
// loopback in both phase settings and a MISO-tied-low, MOSI-idle-high configuration.
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] bus;
    logic        send8, send16, sendz;

    logic        ack8, rxs8, sclk8, ss8, mosi8;
    logic [7:0]  rxd8;
    logic        ack16, rxs16, sclk16, ss16, mosi16;
    logic [15:0] rxd16;
    logic        ackz, rxsz, sclkz, ssz, mosiz;
    logic [7:0]  rxdz;

    spi_master #(
        .IDLE_VALUE_for_Clk(1), .IDLE_VALUE_for_MOSI(0), .DATA_VALID_at_FALLING(0),
        .TRAN_WIDTH(8), .Receive_VALID_at_FALLING(0), .CLK_DIV(2)
    ) u_spi8 (
        .c_Clk_High(clk), .i_Rst_n(rst_n), .i_SPI_Send_Sync(send8),
        .i_SPI_Send_Data(bus[7:0]), .o_SPI_Send_Over_ack(ack8),
        .o_SPI_Receive_Sync(rxs8), .o_SPI_Receive_Data(rxd8), .o_SPI_Clk(sclk8),
        .o_SPI_SS(ss8), .o_SPI_MOSI(mosi8), .i_SPI_MISO(mosi8)
    );

    spi_master #(
        .IDLE_VALUE_for_Clk(1), .IDLE_VALUE_for_MOSI(0), .DATA_VALID_at_FALLING(1),
        .TRAN_WIDTH(16), .Receive_VALID_at_FALLING(1), .CLK_DIV(2)
    ) u_spi16 (
        .c_Clk_High(clk), .i_Rst_n(rst_n), .i_SPI_Send_Sync(send16),
        .i_SPI_Send_Data(bus[15:0]), .o_SPI_Send_Over_ack(ack16),
        .o_SPI_Receive_Sync(rxs16), .o_SPI_Receive_Data(rxd16), .o_SPI_Clk(sclk16),
        .o_SPI_SS(ss16), .o_SPI_MOSI(mosi16), .i_SPI_MISO(mosi16)
    );

    spi_master #(
        .IDLE_VALUE_for_Clk(1), .IDLE_VALUE_for_MOSI(1), .DATA_VALID_at_FALLING(0),
        .TRAN_WIDTH(8), .Receive_VALID_at_FALLING(0), .CLK_DIV(2)
    ) u_spiz (
        .c_Clk_High(clk), .i_Rst_n(rst_n), .i_SPI_Send_Sync(sendz),
        .i_SPI_Send_Data(bus[7:0]), .o_SPI_Send_Over_ack(ackz),
        .o_SPI_Receive_Sync(rxsz), .o_SPI_Receive_Data(rxdz), .o_SPI_Clk(sclkz),
        .o_SPI_SS(ssz), .o_SPI_MOSI(mosiz), .i_SPI_MISO(1'b0)
    );

    // Bus monitors: cumulative counters, read as before/after differences by the stimulus.
    int         cyc = 0;
    int         ss_low8 = 0, edges8 = 0, falls8 = 0, ack_cnt8 = 0, rxs_cnt8 = 0, both8 = 0;
    int         ss_fall_cyc8 = 0, ss_rise_cyc8 = 0, last_rise_cyc8 = 0;
    logic [7:0] mosi_seq8 = '0;
    logic [7:0] rx_strobe8 = '0;
    logic       sclk8_prev = 1'b1, ss8_prev = 1'b1;
    int         ss_low16 = 0, ack_cnt16 = 0;
    int         ack_cntz = 0, rxs_cntz = 0, mosi_idle_bad_z = 0, mosi_zero_z = 0;

    always @(negedge clk) begin
        cyc++;
        if (!ss8) ss_low8++;
        if (sclk8 != sclk8_prev) edges8++;
        if (sclk8_prev && !sclk8) falls8++;
        if (!sclk8_prev && sclk8) begin
            mosi_seq8      = {mosi_seq8[6:0], mosi8};
            last_rise_cyc8 = cyc;
        end
        if (ss8_prev && !ss8) ss_fall_cyc8 = cyc;
        if (!ss8_prev && ss8) ss_rise_cyc8 = cyc;
        if (ack8) ack_cnt8++;
        if (rxs8) begin
            rxs_cnt8++;
            rx_strobe8 = rxd8;
        end
        if (ack8 && rxs8) both8++;
        sclk8_prev = sclk8;
        ss8_prev   = ss8;

        if (!ss16) ss_low16++;
        if (ack16) ack_cnt16++;

        if (ackz) ack_cntz++;
        if (rxsz) rxs_cntz++;
        if (ssz && !mosiz) mosi_idle_bad_z++;
        if (!ssz && !mosiz) mosi_zero_z++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input int n);
        repeat (n) @(negedge clk);
    endtask

    int s_ss, s_fall, s_ack, s_rxs, s_both, s_edges;

    initial begin
        rst_n  = 1'b0;
        send8  = 1'b0;
        send16 = 1'b0;
        sendz  = 1'b0;
        bus    = 32'h8080A5A5;
        apply_stimulus(3);

        $display("[TB] reset values");
        check_output("rst_sclk8", 32'(sclk8), 32'd1);
        check_output("rst_ss8", 32'(ss8), 32'd1);
        check_output("rst_mosi8", 32'(mosi8), 32'd0);
        check_output("rst_ack8", 32'(ack8), 32'd0);
        check_output("rst_rxs8", 32'(rxs8), 32'd0);
        check_output("rst_rxd8", 32'(rxd8), 32'd0);
        check_output("rst_rxd16", 32'(rxd16), 32'd0);
        check_output("rst_mosiz", 32'(mosiz), 32'd1);
        rst_n = 1'b1;
        apply_stimulus(2);

        $display("[TB] 8-bit loopback");
        s_ss = ss_low8; s_fall = falls8; s_ack = ack_cnt8; s_rxs = rxs_cnt8; s_both = both8;
        send8 = 1'b1;
        for (int i = 0; i < 200 && ack_cnt8 == s_ack; i++) @(negedge clk);
        check_output("xfer8_done", 32'(ack_cnt8 != s_ack), 32'd1);
        apply_stimulus(3);
        send8 = 1'b0;
        apply_stimulus(2);
        check_output("xfer8_ss_low", ss_low8 - s_ss, 32'd34);
        check_output("xfer8_sclk_pulses", falls8 - s_fall, 32'd8);
        check_output("xfer8_mosi_seq", 32'(mosi_seq8), 32'hA5);
        check_output("xfer8_ack_cycles", ack_cnt8 - s_ack, 32'd1);
        check_output("xfer8_rxs_cycles", rxs_cnt8 - s_rxs, 32'd1);
        check_output("xfer8_strobes_aligned", both8 - s_both, 32'd1);
        check_output("xfer8_rx_at_strobe", 32'(rx_strobe8), 32'hA5);
        check_output("xfer8_rxd", 32'(rxd8), 32'hA5);
        check_output("xfer8_ss_to_last_edge", last_rise_cyc8 - ss_fall_cyc8, 32'd32);
        check_output("xfer8_last_edge_to_ss", ss_rise_cyc8 - last_rise_cyc8, 32'd2);
        check_output("xfer8_mosi_idle", 32'(mosi8), 32'd0);

        $display("[TB] held request, data changed mid-transfer");
        bus = 32'h0000005A;
        apply_stimulus(1);
        s_ack = ack_cnt8;
        send8 = 1'b1;
        apply_stimulus(6);
        bus = 32'h000000FF;
        apply_stimulus(144);
        send8 = 1'b0;
        apply_stimulus(20);
        check_output("held_ack_cycles", ack_cnt8 - s_ack, 32'd1);
        check_output("held_rxd", 32'(rxd8), 32'h5A);
        check_output("held_mosi_seq", 32'(mosi_seq8), 32'h5A);

        $display("[TB] 16-bit loopback");
        bus  = 32'h8080A5A5;
        apply_stimulus(1);
        s_ss = ss_low16; s_ack = ack_cnt16;
        send16 = 1'b1;
        for (int i = 0; i < 300 && ack_cnt16 == s_ack; i++) @(negedge clk);
        check_output("xfer16_done", 32'(ack_cnt16 != s_ack), 32'd1);
        apply_stimulus(3);
        send16 = 1'b0;
        check_output("xfer16_rxd", 32'(rxd16), 32'hA5A5);
        check_output("xfer16_ss_low", ss_low16 - s_ss, 32'd66);
        check_output("xfer16_ack_cycles", ack_cnt16 - s_ack, 32'd1);
        check_output("xfer16_ss_idle", 32'(ss16), 32'd1);

        $display("[TB] reset mid-transfer");
        s_edges = edges8; s_ack = ack_cnt8; s_rxs = rxs_cnt8;
        send8 = 1'b1;
        for (int i = 0; i < 100 && (edges8 - s_edges) < 3; i++) @(negedge clk);
        check_output("midrst_reached", 32'((edges8 - s_edges) >= 3), 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("midrst_ss", 32'(ss8), 32'd1);
        check_output("midrst_sclk", 32'(sclk8), 32'd1);
        check_output("midrst_mosi", 32'(mosi8), 32'd0);
        check_output("midrst_rxd", 32'(rxd8), 32'd0);
        apply_stimulus(5);
        send8 = 1'b0;
        apply_stimulus(1);
        rst_n = 1'b1;
        apply_stimulus(40);
        check_output("midrst_no_ack", ack_cnt8 - s_ack, 32'd0);
        check_output("midrst_no_rxs", rxs_cnt8 - s_rxs, 32'd0);
        check_output("midrst_rxd_after", 32'(rxd8), 32'd0);

        bus   = 32'h0000003C;
        s_ack = ack_cnt8;
        send8 = 1'b1;
        for (int i = 0; i < 200 && ack_cnt8 == s_ack; i++) @(negedge clk);
        check_output("after_rst_done", 32'(ack_cnt8 != s_ack), 32'd1);
        apply_stimulus(2);
        send8 = 1'b0;
        check_output("after_rst_rxd", 32'(rxd8), 32'h3C);
        check_output("after_rst_mosi_seq", 32'(mosi_seq8), 32'h3C);
        check_output("after_rst_rx_at_strobe", 32'(rx_strobe8), 32'h3C);

        $display("[TB] MISO tied low, MOSI idle high");
        bus   = 32'h8080A5A5;
        apply_stimulus(1);
        s_ack = ack_cntz; s_rxs = rxs_cntz;
        sendz = 1'b1;
        for (int i = 0; i < 200 && ack_cntz == s_ack; i++) @(negedge clk);
        check_output("tied_done", 32'(ack_cntz != s_ack), 32'd1);
        apply_stimulus(3);
        sendz = 1'b0;
        check_output("tied_rxd", 32'(rxdz), 32'h00);
        check_output("tied_ack_cycles", ack_cntz - s_ack, 32'd1);
        check_output("tied_rxs_cycles", rxs_cntz - s_rxs, 32'd1);
        check_output("tied_mosi_idle_when_ss_high", mosi_idle_bad_z, 32'd0);
        check_output("tied_mosi_active", 32'(mosi_zero_z > 0), 32'd1);
        check_output("tied_mosi_after", 32'(mosiz), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
